// File: rtl/reg_file.sv
// 8 x 8-bit register file, two combinational read ports and one write port behind a one-entry write-back register.
// Define REGFILE_WB_BYPASS_EN to forward the pending write-back data on a read hit instead of raising STALL.
module reg_file (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IN,
  input  logic [2:0] INADDRESS,
  input  logic       WRITE,
  input  logic [2:0] OUT1ADDRESS,
  input  logic [2:0] OUT2ADDRESS,
  output logic [7:0] OUT1,
  output logic [7:0] OUT2,
  output logic       STALL,
  output logic       WBVALID
);

  logic [7:0] regs [8];
  logic       wbValid;
  logic [2:0] wbAddr;
  logic [7:0] wbData;
  logic       hit1;
  logic       hit2;

  // Each edge retires the old write-back entry into the array and captures the new write.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 8'h00;
      end
      wbValid <= 1'b0;
      wbAddr  <= 3'd0;
      wbData  <= 8'h00;
    end else begin
      if (wbValid) begin
        regs[wbAddr] <= wbData;
      end
      wbValid <= WRITE;
      if (WRITE) begin
        wbAddr <= INADDRESS;
        wbData <= IN;
      end
    end
  end

  assign hit1    = wbValid && (wbAddr == OUT1ADDRESS);
  assign hit2    = wbValid && (wbAddr == OUT2ADDRESS);
  assign WBVALID = wbValid;

`ifdef REGFILE_WB_BYPASS_EN
  assign OUT1  = hit1 ? wbData : regs[OUT1ADDRESS];
  assign OUT2  = hit2 ? wbData : regs[OUT2ADDRESS];
  assign STALL = 1'b0;
`else
  // Without forwarding the array value is stale on a hit, so the consumer is told to wait.
  assign OUT1  = regs[OUT1ADDRESS];
  assign OUT2  = regs[OUT2ADDRESS];
  assign STALL = hit1 || hit2;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a directed vector table plus hand-written reset and ALU-operand sequences.
// Expectations follow REGFILE_WB_BYPASS_EN the same way the design build does.
module tb_reg_file;

  logic       CLK;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic [7:0] OUT1;
  logic [7:0] OUT2;
  logic       STALL;
  logic       WBVALID;

  int checkCount = 0;
  int passCount  = 0;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  typedef struct {
    logic       write;
    logic [2:0] inAddr;
    logic [7:0] inData;
    logic [2:0] rd1;
    logic [2:0] rd2;
    logic [7:0] fwd1;
    logic [7:0] fwd2;
    logic [7:0] stale1;
    logic [7:0] stale2;
    logic       hazard;
    logic       wbValid;
  } vec_t;

  vec_t vecs [13];

  reg_file dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1), .OUT2(OUT2), .STALL(STALL), .WBVALID(WBVALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle's inputs mid-cycle, then sample 2 time units after the rising edge.
  task automatic applyStimulus(input logic w, input logic [2:0] a, input logic [7:0] d,
                               input logic [2:0] r1, input logic [2:0] r2);
    @(negedge CLK);
    WRITE = w; INADDRESS = a; IN = d; OUT1ADDRESS = r1; OUT2ADDRESS = r2;
    @(posedge CLK);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] e1, input logic [7:0] e2,
                             input logic eStall, input logic eWb);
    checkCount++;
    if (OUT1 === e1 && OUT2 === e2 && STALL === eStall && WBVALID === eWb) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got OUT1=%h OUT2=%h STALL=%b WBVALID=%b, want OUT1=%h OUT2=%h STALL=%b WBVALID=%b",
               name, OUT1, OUT2, STALL, WBVALID, e1, e2, eStall, eWb);
    end
  endtask

  function automatic vec_t mk(logic w, logic [2:0] a, logic [7:0] d, logic [2:0] r1, logic [2:0] r2,
                              logic [7:0] f1, logic [7:0] f2, logic [7:0] s1, logic [7:0] s2,
                              logic hz, logic wb);
    vec_t v;
    v.write = w; v.inAddr = a; v.inData = d; v.rd1 = r1; v.rd2 = r2;
    v.fwd1 = f1; v.fwd2 = f2; v.stale1 = s1; v.stale2 = s2; v.hazard = hz; v.wbValid = wb;
    return v;
  endfunction

  initial begin
    logic [7:0] aluResult;
    logic       aluZero;

    // write, addr, data, rd1, rd2, fwd1, fwd2, stale1, stale2, hazard, wbValid
    vecs[0]  = mk(1, 5, 8'hA7, 5, 5, 8'hA7, 8'hA7, 8'h00, 8'h00, 1, 1);
    vecs[1]  = mk(0, 0, 8'h00, 5, 0, 8'hA7, 8'h00, 8'hA7, 8'h00, 0, 0);
    vecs[2]  = mk(1, 2, 8'h11, 2, 5, 8'h11, 8'hA7, 8'h00, 8'hA7, 1, 1);
    vecs[3]  = mk(1, 2, 8'h22, 2, 2, 8'h22, 8'h22, 8'h11, 8'h11, 1, 1);
    vecs[4]  = mk(0, 0, 8'h00, 2, 5, 8'h22, 8'hA7, 8'h22, 8'hA7, 0, 0);
    vecs[5]  = mk(1, 0, 8'h3C, 1, 3, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
    vecs[6]  = mk(0, 0, 8'h00, 0, 2, 8'h3C, 8'h22, 8'h3C, 8'h22, 0, 0);
    vecs[7]  = mk(1, 7, 8'h01, 7, 6, 8'h01, 8'h00, 8'h00, 8'h00, 1, 1);
    vecs[8]  = mk(1, 7, 8'h02, 7, 6, 8'h02, 8'h00, 8'h01, 8'h00, 1, 1);
    vecs[9]  = mk(1, 7, 8'h03, 7, 6, 8'h03, 8'h00, 8'h02, 8'h00, 1, 1);
    vecs[10] = mk(0, 0, 8'h00, 7, 7, 8'h03, 8'h03, 8'h03, 8'h03, 0, 0);
    vecs[11] = mk(1, 4, 8'h0F, 6, 6, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
    vecs[12] = mk(0, 0, 8'h00, 4, 4, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 0, 0);

    RESET = 1'b0; WRITE = 1'b0; INADDRESS = 3'd0; IN = 8'h00; OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd7;
    #12;
    checkOutput("reset_state", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].write, vecs[i].inAddr, vecs[i].inData, vecs[i].rd1, vecs[i].rd2);
      checkOutput($sformatf("vec%0d", i),
                  Bypass ? vecs[i].fwd1 : vecs[i].stale1,
                  Bypass ? vecs[i].fwd2 : vecs[i].stale2,
                  vecs[i].hazard && !Bypass, vecs[i].wbValid);
    end

    // ALU operands from a dual-port read of r4: add gives 0x1E, not zero.
    aluResult = OUT1 + OUT2;
    aluZero   = (aluResult == 8'h00);
    checkCount++;
    if (aluResult === 8'h1E && aluZero === 1'b0) passCount++;
    else $display("[TB] FAIL alu_add: got RESULT=%h ZERO=%b, want RESULT=1e ZERO=0", aluResult, aluZero);

    // Commit 0x55 to r3, capture 0xFF to r1, then reset between edges.
    applyStimulus(1, 3, 8'h55, 3, 1);
    applyStimulus(1, 1, 8'hFF, 3, 1);
    checkOutput("r3_committed", 8'h55, Bypass ? 8'hFF : 8'h00, !Bypass, 1'b1);
    #1 RESET = 1'b0;
    #2;
    checkOutput("async_reset", 8'h00, 8'h00, 1'b0, 1'b0);
    WRITE = 1'b0;
    #1 RESET = 1'b1;
    applyStimulus(0, 0, 8'h00, 1, 3);
    checkOutput("post_reset_1", 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus(0, 0, 8'h00, 1, 3);
    checkOutput("post_reset_2", 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset release between edges must not commit anything by itself.
    applyStimulus(1, 6, 8'h99, 6, 6);
    checkOutput("r6_capture", Bypass ? 8'h99 : 8'h00, Bypass ? 8'h99 : 8'h00, !Bypass, 1'b1);
    applyStimulus(0, 0, 8'h00, 6, 0);
    checkOutput("r6_commit", 8'h99, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
